// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared widths and FSM encoding for the Horner quadratic evaluator
package poly_pkg;

    localparam int XW_DEF = 8;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP1 = 2'd1,
        STEP2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/poly_mac.sv
// rtl/poly_mac.sv - combinational acc*x + addend, wrapped to CW bits
module poly_mac #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] acc,
    input  logic [CW-1:0] mult,
    input  logic [CW-1:0] addend,
    output logic [CW-1:0] result
);

    // Low CW bits of a two's-complement product do not depend on signedness.
    assign result = acc * mult + addend;

endmodule

// File: rtl/poly_horner_ctrl.sv
// rtl/poly_horner_ctrl.sv - sequenced y = (a*x + b)*x + c on one shared multiply-add
module poly_horner_ctrl
    import poly_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic          enable,
    output logic [CW-1:0] y,
    output logic          ready,
    output logic          valid
);

    state_t        state;
    state_t        state_nxt;
    logic          start;
    logic          acc_ld;
    logic          valid_r;
    logic [XW-1:0] x_r;
    logic [CW-1:0] a_r;
    logic [CW-1:0] b_r;
    logic [CW-1:0] c_r;
    logic [CW-1:0] acc;
    logic [CW-1:0] x_ext;
    logic [CW-1:0] mac_acc;
    logic [CW-1:0] mac_add;
    logic [CW-1:0] mac_out;

    assign x_ext = {{(CW-XW){x_r[XW-1]}}, x_r};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = STEP1;
            STEP1:   state_nxt = STEP2;
            STEP2:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The result is published on the edge leaving DONE, so the valid cycle is
    // already IDLE; ready is held low there to keep valid and ready disjoint.
    always_comb begin
        start   = 1'b0;
        acc_ld  = 1'b0;
        mac_acc = acc;
        mac_add = c_r;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                start = enable;
                ready = !valid_r;
            end
            STEP1: begin
                acc_ld  = 1'b1;
                mac_acc = a_r;
                mac_add = b_r;
            end
            STEP2: begin
                acc_ld = 1'b1;
            end
            default: ;
        endcase
    end

    poly_mac #(.CW(CW)) u_mac (
        .acc    (mac_acc),
        .mult   (x_ext),
        .addend (mac_add),
        .result (mac_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            acc     <= '0;
            y       <= '0;
            valid_r <= 1'b0;
        end else begin
            if (start) begin
                x_r <= x;
                a_r <= a;
                b_r <= b;
                c_r <= c;
            end
            if (acc_ld) begin
                acc <= mac_out;
            end
            if (state == DONE) begin
                y <= acc;
            end
            valid_r <= (state == DONE);
        end
    end

    assign valid = valid_r;

endmodule
